ifetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch unit. Fetches one cache line of LINE_WORDS instructions per accepted access into a DEPTH-entry fetch queue.
- The queue decouples the I-cache from decode using a valid/ready handshake.
- Sits between the I-cache read port and the decode stage.
- Adds over the previous fetch unit: buffering, per-line word masks, flush on redirect, and width/depth generalisation.

---
 rtl/ifetch_queue.sv | 158 +++++++++++++++
 tb/tb_ifetch_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: fetches whole cache lines into a DEPTH-entry queue feeding decode.
// Optional statistics counters are enabled by defining IFETCH_QUEUE_STATS_EN.
module ifetch_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    output logic [ADDR_WIDTH-1:0]      cache_addr,
    output logic                       cache_rd,
    input  logic [LINE_WORDS*32-1:0]   cache_data,
    input  logic                       cache_waitrequest,
    input  logic                       load_pc,
    input  logic [ADDR_WIDTH-1:0]      new_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LINE_WORDS*32-1:0]   out_words,
    output logic [LINE_WORDS-1:0]      out_mask,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic                       fetch_busy
`ifdef IFETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]                stat_lines,
    output logic [31:0]                stat_wait_cycles,
    output logic [31:0]                stat_flushes
`endif
);

    localparam int unsigned LINE_W     = LINE_WORDS * 32;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_LSB = ADDR_WIDTH'(LINE_BYTES - 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LINE_W-1:0]     mem_words_q [DEPTH];
    logic [LINE_W-1:0]     mem_words_d [DEPTH];
    logic [LINE_WORDS-1:0] mem_mask_q  [DEPTH];
    logic [LINE_WORDS-1:0] mem_mask_d  [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_d    [DEPTH];

    logic [ADDR_WIDTH-1:0] line_base_c;
    logic [3:0]            off_c;
    logic [LINE_WORDS-1:0] line_mask_c;
    logic                  enq_c, deq_c, empty_c;

    // Handshake terms; redirect suppresses both sides of the queue.
    always_comb begin
        empty_c     = (count_q == '0);
        cache_rd    = (count_q < CNT_W'(DEPTH)) & ~load_pc;
        cache_addr  = pc_q;
        fetch_busy  = cache_rd & cache_waitrequest;
        out_valid   = ~empty_c & ~load_pc;
        enq_c       = cache_rd & ~cache_waitrequest;
        deq_c       = out_valid & out_ready;
        line_base_c = pc_q & ~LINE_LSB;
        off_c       = 4'((pc_q & LINE_LSB) >> 2);
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_mask_c[i] = (4'(i) >= off_c);
        end
        out_words = empty_c ? '0 : mem_words_q[rd_ptr_q];
        out_mask  = empty_c ? '0 : mem_mask_q[rd_ptr_q];
        out_pc    = empty_c ? '0 : mem_pc_q[rd_ptr_q];
    end

    // Next-state for PC, pointers, occupancy and queue storage.
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_words_d = mem_words_q;
        mem_mask_d  = mem_mask_q;
        mem_pc_d    = mem_pc_q;
        if (load_pc) begin
            pc_d     = {new_pc[ADDR_WIDTH-1:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_c) begin
                mem_words_d[wr_ptr_q] = cache_data;
                mem_mask_d[wr_ptr_q]  = line_mask_c;
                mem_pc_d[wr_ptr_q]    = line_base_c;
                wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
                pc_d     = line_base_c + ADDR_WIDTH'(LINE_BYTES);
            end
            if (deq_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            if (enq_c && !deq_c) begin
                count_d = CNT_W'(count_q + 1'b1);
            end else if (!enq_c && deq_c) begin
                count_d = CNT_W'(count_q - 1'b1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_words_q[i] <= '0;
                mem_mask_q[i]  <= '0;
                mem_pc_q[i]    <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_words_q <= mem_words_d;
            mem_mask_q  <= mem_mask_d;
            mem_pc_q    <= mem_pc_d;
        end
    end

`ifdef IFETCH_QUEUE_STATS_EN
    logic [31:0] stat_lines_q, stat_lines_d;
    logic [31:0] stat_wait_q, stat_wait_d;
    logic [31:0] stat_flush_q, stat_flush_d;

    // Saturating event counters.
    always_comb begin
        stat_lines_d = stat_lines_q;
        stat_wait_d  = stat_wait_q;
        stat_flush_d = stat_flush_q;
        if (enq_c && stat_lines_q != '1) stat_lines_d = stat_lines_q + 32'd1;
        if (fetch_busy && stat_wait_q != '1) stat_wait_d = stat_wait_q + 32'd1;
        if (load_pc && !empty_c && stat_flush_q != '1) stat_flush_d = stat_flush_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_lines_q <= '0;
            stat_wait_q  <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_lines_q <= stat_lines_d;
            stat_wait_q  <= stat_wait_d;
            stat_flush_q <= stat_flush_d;
        end
    end

    assign stat_lines       = stat_lines_q;
    assign stat_wait_cycles = stat_wait_q;
    assign stat_flushes     = stat_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LB    = LW * 4;
    localparam logic [AW-1:0] RST_PC = 32'h0;
    localparam int NCYC = 2000;

    typedef struct {
        logic [LW*32-1:0] w;
        logic [LW-1:0]    m;
        logic [AW-1:0]    pc;
    } bundle_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [AW-1:0]    cache_addr;
    logic             cache_rd;
    logic [LW*32-1:0] cache_data;
    logic             cache_waitrequest;
    logic             load_pc;
    logic [AW-1:0]    new_pc;
    logic             out_valid;
    logic             out_ready;
    logic [LW*32-1:0] out_words;
    logic [LW-1:0]    out_mask;
    logic [AW-1:0]    out_pc;
    logic             fetch_busy;
`ifdef IFETCH_QUEUE_STATS_EN
    logic [31:0] stat_lines, stat_wait_cycles, stat_flushes;
    int m_lines, m_waits, m_flushes;
`endif

    ifetch_queue #(.ADDR_WIDTH(AW), .LINE_WORDS(LW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset_n(reset_n),
        .cache_addr(cache_addr), .cache_rd(cache_rd), .cache_data(cache_data),
        .cache_waitrequest(cache_waitrequest),
        .load_pc(load_pc), .new_pc(new_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_words(out_words),
        .out_mask(out_mask), .out_pc(out_pc), .fetch_busy(fetch_busy)
`ifdef IFETCH_QUEUE_STATS_EN
        , .stat_lines(stat_lines), .stat_wait_cycles(stat_wait_cycles), .stat_flushes(stat_flushes)
`endif
    );

    always #5 clock = ~clock;

    int      n_tests = 0;
    int      n_fail  = 0;
    int      n_deq   = 0;
    bundle_t exp_q[$];
    logic [AW-1:0] m_pc = RST_PC;

    task automatic check(input string name, input logic [LW*32-1:0] act, input logic [LW*32-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pushes expected bundles and checks fetch-side outputs.
    always @(negedge clock) begin
        bundle_t b;
        logic e_rd;
        int unsigned off;
        if (!reset_n) begin
            check("rst_out_valid", 128'(out_valid), 128'(0));
            check("rst_out_mask", 128'(out_mask), 128'(0));
            check("rst_out_words", out_words, 128'(0));
            check("rst_out_pc", 128'(out_pc), 128'(0));
            check("rst_cache_rd", 128'(cache_rd), 128'(1));
            check("rst_cache_addr", 128'(cache_addr), 128'(RST_PC));
            exp_q.delete();
            m_pc = RST_PC;
`ifdef IFETCH_QUEUE_STATS_EN
            m_lines = 0; m_waits = 0; m_flushes = 0;
`endif
        end else begin
            e_rd = (exp_q.size() < DEPTH) && !load_pc;
            check("cache_rd", 128'(cache_rd), 128'(e_rd));
            check("cache_addr", 128'(cache_addr), 128'(m_pc));
            check("fetch_busy", 128'(fetch_busy), 128'(e_rd && cache_waitrequest));
            check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0 && !load_pc));
            if (exp_q.size() == 0) begin
                check("empty_mask", 128'(out_mask), 128'(0));
                check("empty_pc", 128'(out_pc), 128'(0));
            end
`ifdef IFETCH_QUEUE_STATS_EN
            if (e_rd && cache_waitrequest) m_waits++;
            if (load_pc && exp_q.size() != 0) m_flushes++;
            if (e_rd && !cache_waitrequest) m_lines++;
`endif
            if (load_pc) begin
                exp_q.delete();
                m_pc = {new_pc[AW-1:2], 2'b00};
            end else if (e_rd && !cache_waitrequest) begin
                off  = (m_pc % LB) / 4;
                b.w  = cache_data;
                b.pc = m_pc - (m_pc % LB);
                for (int i = 0; i < LW; i++) b.m[i] = (i >= off);
                exp_q.push_back(b);
                m_pc = b.pc + LB;
            end
        end
    end

    // Monitor: compares each dequeued bundle with the scoreboard head.
    always @(negedge clock) begin
        bundle_t b;
        #1;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bundle", 128'(out_valid), 128'(0));
            end else begin
                b = exp_q.pop_front();
                n_deq++;
                check("out_words", out_words, b.w);
                check("out_mask", 128'(out_mask), 128'(b.m));
                check("out_pc", 128'(out_pc), 128'(b.pc));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        cache_data = '0;
        cache_waitrequest = 1'b0;
        load_pc = 1'b0;
        new_pc = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < NCYC; i++) begin
            cache_data = {$urandom, $urandom, $urandom, $urandom};
            out_ready = (i < 40) ? 1'b1 : (i < 60) ? 1'b0 : ($urandom_range(9) < 7);
            if (i < 60)
                cache_waitrequest = 1'b0;
            else if (i >= 100 && i < 105)
                cache_waitrequest = 1'b1;
            else
                cache_waitrequest = ($urandom_range(3) == 0);
            load_pc = 1'b0;
            if (i == 80) begin
                load_pc = 1'b1; new_pc = 32'h108;
            end else if (i == 200) begin
                load_pc = 1'b1; new_pc = 32'hFFFF_FFE4;
            end else if (i > 110 && $urandom_range(24) == 0) begin
                load_pc = 1'b1;
                new_pc = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFC0 | 32'($urandom_range(63)));
            end
            if (i == 600) reset_n = 1'b0;
            if (i == 602) reset_n = 1'b1;
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        #2;
        check("bundles_seen", 128'(n_deq > 100), 128'(1));
`ifdef IFETCH_QUEUE_STATS_EN
        check("stat_lines", 128'(stat_lines), 128'(m_lines));
        check("stat_wait_cycles", 128'(stat_wait_cycles), 128'(m_waits));
        check("stat_flushes", 128'(stat_flushes), 128'(m_flushes));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
